// File: rtl/latch_regfile.sv
// Latch-array register file: DEPTH x WIDTH words in level-sensitive latches, written through a one-entry flop stage.
// Latency: write visible via bypass right after the accepting edge, held in the latch before the next edge; reads are combinational.
// Backpressure: wr_ready drops while a clear sweep runs or rst is high; writes to addresses >= DEPTH are accepted and dropped.
module latch_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             clr,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Address bounds widened by one bit so DEPTH itself is representable.
    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    state_t                      r_state;
    logic                        r_busy;
    logic [AW-1:0]               r_sweep_ptr;
    logic                        r_pend_vld;
    logic [AW-1:0]               r_pend_addr;
    logic [WIDTH-1:0]            r_pend_dat;

    logic                        w_wr_acc;
    logic                        w_wr_in_rng;
    logic                        w_rd_in_rng;
    logic                        w_bypass;
    logic [DEPTH-1:0]            w_gate;
    logic [DEPTH-1:0][WIDTH-1:0] w_words;

    assign busy        = r_busy;
    assign wr_ready    = !r_busy && !rst;
    assign w_wr_acc    = wr_valid && wr_ready;
    assign w_wr_in_rng = ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rd_in_rng = ({1'b0, rd_addr} < LP_DEPTH);
    assign w_bypass    = r_pend_vld && (r_pend_addr == rd_addr);

    // Sweep FSM and staging register: accepted writes or sweep zeros are staged for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SWEEP;
            r_busy      <= 1'b1;
            r_sweep_ptr <= '0;
            r_pend_vld  <= 1'b0;
        end else begin
            r_pend_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A write accepted alongside clr still lands; the sweep zeroes it later.
                    if (w_wr_acc) begin
                        // Out-of-range writes complete the handshake but never stage.
                        r_pend_vld  <= w_wr_in_rng;
                        r_pend_addr <= wr_addr;
                        r_pend_dat  <= wr_data;
                    end
                    if (clr) begin
                        r_state     <= ST_SWEEP;
                        r_busy      <= 1'b1;
                        r_sweep_ptr <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_pend_vld  <= 1'b1;
                    r_pend_addr <= r_sweep_ptr;
                    r_pend_dat  <= '0;
                    if (r_sweep_ptr == LP_LAST) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_sweep_ptr <= '0;
                    end else begin
                        r_sweep_ptr <= r_sweep_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SWEEP;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // One latch word per address; its gate opens only in the low half of the cycle after staging.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [WIDTH-1:0] r_word;

        // Gate built only from flop outputs qualified by !clk, so it cannot glitch open.
        assign w_gate[gi] = r_pend_vld && !clk && (r_pend_addr == AW'(gi));

        // Transparent while the gate is open, holds otherwise.
        always_latch begin
            if (w_gate[gi]) begin
                r_word <= r_pend_dat;
            end
        end

        assign w_words[gi] = r_word;
    end

    // Read mux: forced zero while sweeping or out of range, staged data bypasses the latch.
    always_comb begin
        rd_data = '0;
        if (!r_busy && w_rd_in_rng) begin
            if (w_bypass) begin
                rd_data = r_pend_dat;
            end else begin
                rd_data = w_words[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_latch_regfile.sv
module tb_latch_regfile;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH = 8 instance
    logic       rst, wr_valid, wr_ready, clr, busy;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    // DEPTH = 6 instance for out-of-range addressing
    logic       rst6, wr_valid6, wr_ready6, clr6, busy6;
    logic [2:0] wr_addr6, rd_addr6;
    logic [7:0] wr_data6, rd_data6;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cnt;
    logic [7:0] exp_mem [8];

    latch_regfile #(.WIDTH(8), .DEPTH(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .clr      (clr),
        .busy     (busy)
    );

    latch_regfile #(.WIDTH(8), .DEPTH(6)) u_dut6 (
        .clk      (clk),
        .rst      (rst6),
        .wr_valid (wr_valid6),
        .wr_ready (wr_ready6),
        .wr_addr  (wr_addr6),
        .wr_data  (wr_data6),
        .rd_addr  (rd_addr6),
        .rd_data  (rd_data6),
        .clr      (clr6),
        .busy     (busy6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single write to the DEPTH=8 instance; checks that it is accepted.
    task automatic wr8(input logic [2:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        check("wr_ready_at_accept", {31'b0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        exp_mem[a] = d;
    endtask

    // Reads every word against the bench's expected contents.
    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step();
            check(tag, {24'b0, rd_data}, {24'b0, exp_mem[i]});
        end
    endtask

    // Counts cycles with busy high; reads must be zero and wr_ready low throughout.
    task automatic sweep_count(output int c, input int clr_at);
        c = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy !== 1'b1) break;
            check("wr_ready_low_in_sweep", {31'b0, wr_ready}, 32'd0);
            rd_addr = 3'(k % 8);
            #1;
            check("rd_zero_in_sweep", {24'b0, rd_data}, 32'd0);
            c++;
            if (k == clr_at) clr = 1'b1;
            step();
            clr = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; clr = 1'b0;
        rst6 = 1'b1; wr_valid6 = 1'b0; wr_addr6 = '0; wr_data6 = '0; rd_addr6 = '0; clr6 = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;

        // Reset sweep: one-cycle rst gives 8 busy cycles, then all zero
        step();
        rst = 1'b0; rst6 = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_rd_data", {24'b0, rd_data}, 32'd0);
        sweep_count(cnt, -1);
        check("reset_sweep_len", cnt, 8);
        check("wr_ready_after_sweep", {31'b0, wr_ready}, 32'd1);
        read_all("reset_read_zero");

        // Write and bypass
        rd_addr = 3'd3;
        step();
        wr8(3'd3, 8'hA5);
        check("bypass_a5", {24'b0, rd_data}, 32'hA5);
        step();
        check("latched_a5", {24'b0, rd_data}, 32'hA5);
        wr8(3'd4, 8'h3C);
        check("a5_after_unrelated_wr", {24'b0, rd_data}, 32'hA5);
        step();
        check("a5_held", {24'b0, rd_data}, 32'hA5);

        // Back-to-back writes, same-address overwrite
        wr8(3'd2, 8'h11);
        wr8(3'd2, 8'h22);
        wr8(3'd5, 8'h33);
        read_all("b2b_read");

        // Clear during traffic
        for (int i = 0; i < 8; i++) wr8(3'(i), 8'hFF);
        read_all("fill_ff_read");
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'h5A; clr = 1'b1; rd_addr = 3'd1;
        check("clr_wr_accept", {31'b0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0; clr = 1'b0;
        check("clr_busy", {31'b0, busy}, 32'd1);
        sweep_count(cnt, -1);
        check("clr_sweep_len", cnt, 8);
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
        read_all("clr_read_zero");

        // Mid-sweep events: rst restarts the sweep, clr does not extend it
        wr8(3'd7, 8'h99);
        wr8(3'd0, 8'h66);
        rst = 1'b1;
        #1;
        check("wr_ready_low_on_rst", {31'b0, wr_ready}, 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_count(cnt, 2);
        check("restart_sweep_len", cnt, 8);
        check("busy_after_restart", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
        read_all("restart_read_zero");

        // Out-of-range on DEPTH=6 instance
        check("d6_idle", {31'b0, busy6}, 32'd0);
        wr_valid6 = 1'b1; wr_addr6 = 3'd3; wr_data6 = 8'h42;
        step();
        wr_valid6 = 1'b0;
        rd_addr6 = 3'd3;
        step();
        check("d6_word3", {24'b0, rd_data6}, 32'h42);
        wr_valid6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 8'h77; rd_addr6 = 3'd7;
        check("d6_oor_ready", {31'b0, wr_ready6}, 32'd1);
        step();
        wr_valid6 = 1'b0;
        check("d6_oor_rd_bypass", {24'b0, rd_data6}, 32'd0);
        step();
        check("d6_oor_rd7", {24'b0, rd_data6}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr6 = 3'(i);
            step();
            check("d6_word_after_oor", {24'b0, rd_data6}, (i == 3) ? 32'h42 : 32'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
